// File: rtl/fifo_rd_adapter.sv
// Turns a 1-cycle-latency FIFO read port into a valid/ready stream through a
// 2-entry in-order skid buffer, with a sticky underflow flag and a handshake counter.
module fifo_rd_adapter #(
    parameter int FIFO_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_empty,
    input  logic [FIFO_WIDTH-1:0]  fifo_data_out,
    input  logic                   fifo_underflow,
    output logic                   fifo_rd_en,
    output logic                   m_valid,
    output logic [FIFO_WIDTH-1:0]  m_data,
    input  logic                   m_ready,
    output logic                   underflow_err,
    output logic [COUNT_WIDTH-1:0] rd_count
);

    logic [1:0]             r_occ;
    logic                   r_inflight;
    logic                   r_head;
    logic                   r_tail;
    logic [FIFO_WIDTH-1:0]  r_buf [2];
    logic                   r_underflow_err;
    logic [COUNT_WIDTH-1:0] r_rd_count;

    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic [2:0]             w_committed;

    // Stream handshake: a word transfers on every cycle where m_valid && m_ready.
    // m_valid never depends on m_ready; m_data holds while m_valid && !m_ready.
    assign m_valid = !rst && (r_occ != 2'd0);
    assign m_data  = rst ? '0 : r_buf[r_head];
    assign w_pop   = m_valid && m_ready;

    // Slots already spoken for once this cycle's pop leaves; the m_ready -> rd_en
    // combinational path is what lets the adapter sustain one word per cycle.
    assign w_committed = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign fifo_rd_en  = !rst && !fifo_empty && (w_committed < 3'd2);

    assign w_push = r_inflight && !fifo_underflow;
    assign w_drop = r_inflight && fifo_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ           <= 2'd0;
            r_inflight      <= 1'b0;
            r_head          <= 1'b0;
            r_tail          <= 1'b0;
            r_buf[0]        <= '0;
            r_buf[1]        <= '0;
            r_underflow_err <= 1'b0;
            r_rd_count      <= '0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (w_push) begin
                r_buf[r_tail] <= fifo_data_out;
                r_tail        <= ~r_tail;
            end
            if (w_pop) begin
                r_head     <= ~r_head;
                r_rd_count <= r_rd_count + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
            if (w_drop) begin
                r_underflow_err <= 1'b1;
            end
        end
    end

    assign underflow_err = r_underflow_err;
    assign rd_count      = r_rd_count;

    // The read-issue rule reserves a slot for every word in flight, so a push into a
    // full buffer without a matching pop can never happen.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && (r_occ == 2'd2)));

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Bench for fifo_rd_adapter: a queue-based FIFO environment, a queue-level reference
// model checked every cycle, directed scenarios with literal expectations, random traffic.
module tb_fifo_rd_adapter;

    localparam int W  = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic [W-1:0]  fifo_data_out;
    logic          fifo_underflow;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_ready;
    logic          underflow_err;
    logic [CW-1:0] rd_count;

    int checks = 0;
    int errors = 0;

    // Environment state: words the bench wants to load, the FIFO contents,
    // and a one-shot request to report underflow on the next read.
    logic [W-1:0] load_q[$];
    logic [W-1:0] fifo_q[$];
    logic         inj_req;

    // Reference model: words sitting in the output buffer, a read in flight,
    // sticky error, delivered count; plus observed handshake data for literal checks.
    logic [W-1:0]  buf_q[$];
    logic          m_infl = 1'b0;
    logic          m_err  = 1'b0;
    logic [CW-1:0] m_cnt  = '0;
    logic [W-1:0]  got_q[$];
    int            hs_cnt = 0;

    fifo_rd_adapter #(.FIFO_WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .fifo_data_out  (fifo_data_out),
        .fifo_underflow (fifo_underflow),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready),
        .underflow_err  (underflow_err),
        .rd_count       (rd_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Environment + model + per-cycle compare. Samples on the falling edge,
    // applies FIFO responses just after the rising edge.
    initial begin : env
        logic         exp_v, exp_rd, exp_pop, rd_act, rst_now;
        logic [W-1:0] exp_d;
        forever begin
            @(negedge clk);
            rst_now = rst;
            rd_act  = fifo_rd_en;
            if (rst_now) begin
                exp_v   = 1'b0;
                exp_d   = '0;
                exp_rd  = 1'b0;
                exp_pop = 1'b0;
            end else begin
                exp_v   = (buf_q.size() != 0);
                exp_d   = exp_v ? buf_q[0] : '0;
                exp_pop = exp_v && m_ready;
                exp_rd  = !fifo_empty && ((buf_q.size() + int'(m_infl) - int'(exp_pop)) < 2);
            end
            chk("m_valid", m_valid, exp_v);
            chk("fifo_rd_en", fifo_rd_en, exp_rd);
            if (exp_v || rst_now) chk("m_data", m_data, exp_d);
            chk("rd_count", rd_count, m_cnt);
            chk("underflow_err", underflow_err, m_err);
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                hs_cnt++;
            end

            if (rst_now) begin
                buf_q.delete();
                m_infl = 1'b0;
                m_err  = 1'b0;
                m_cnt  = '0;
                hs_cnt = 0;
            end else begin
                if (exp_pop) begin
                    void'(buf_q.pop_front());
                    m_cnt = m_cnt + 1'b1;
                end
                if (m_infl) begin
                    if (fifo_underflow) m_err = 1'b1;
                    else buf_q.push_back(fifo_data_out);
                end
                m_infl = exp_rd;
                chk("occ_bound", (buf_q.size() <= 2), 1);
            end

            @(posedge clk);
            #1;
            if (rst_now) begin
                fifo_q.delete();
                fifo_data_out  = '0;
                fifo_underflow = 1'b0;
            end else if (rd_act) begin
                if (fifo_q.size() == 0) begin
                    fifo_data_out  = W'($urandom);
                    fifo_underflow = 1'b1;
                end else begin
                    fifo_data_out  = fifo_q.pop_front();
                    fifo_underflow = inj_req;
                    inj_req        = 1'b0;
                end
            end else begin
                fifo_data_out  = W'($urandom);
                fifo_underflow = 1'b0;
            end
            while (load_q.size() != 0) fifo_q.push_back(load_q.pop_front());
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    initial begin : stim
        int rd_cyc, v_cyc, pulses, run, maxrun, base, nwords;
        rst            = 1'b1;
        m_ready        = 1'b0;
        inj_req        = 1'b0;
        fifo_empty     = 1'b1;
        fifo_data_out  = '0;
        fifo_underflow = 1'b0;

        // Reset state
        step(2);
        @(negedge clk);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_rd_en", fifo_rd_en, 0);
        chk("reset_rd_count", rd_count, 0);
        chk("reset_err", underflow_err, 0);
        step(1);
        rst = 1'b0;

        // Single word: one read, valid two cycles later
        m_ready = 1'b1;
        load_q.push_back(16'h00A5);
        rd_cyc = -1; v_cyc = -1; pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_rd_en) pulses++;
            if (fifo_rd_en && rd_cyc < 0) rd_cyc = i;
            if (m_valid && v_cyc < 0) begin
                v_cyc = i;
                chk("single_data", m_data, 16'h00A5);
            end
        end
        chk("single_latency", v_cyc - rd_cyc, 2);
        chk("single_rd_pulses", pulses, 1);
        chk("single_count", rd_count, 1);

        // Streaming 8 words back to back
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        got_q.delete();
        for (int i = 1; i <= 8; i++) load_q.push_back(W'(i));
        run = 0; maxrun = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            run = m_valid ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        chk("stream_run", maxrun, 8);
        chk("stream_count", rd_count, 8);
        chk("stream_words", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) chk("stream_order", got_q[i], i + 1);

        // Backpressure: only two reads while stalled, head held
        step(1);
        m_ready = 1'b0;
        got_q.delete();
        base = hs_cnt;
        for (int i = 0; i < 5; i++) load_q.push_back(W'(16'h0010 + i));
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fifo_rd_en) pulses++;
        end
        chk("bp_rd_pulses", pulses, 2);
        chk("bp_model_occ", buf_q.size(), 2);
        chk("bp_valid", m_valid, 1);
        chk("bp_data_held", m_data, 16'h0010);
        step(1);
        m_ready = 1'b1;
        for (int i = 0; i < 40 && (hs_cnt - base) < 5; i++) step(1);
        step(5);
        chk("bp_delivered", hs_cnt - base, 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) chk("bp_order", got_q[i], 16'h0010 + i);
        chk("bp_count", rd_count, 13);

        // Injected underflow on the first read: that word is dropped, flag sticks
        got_q.delete();
        inj_req = 1'b1;
        for (int i = 0; i < 3; i++) load_q.push_back(W'(16'h0020 + i));
        step(15);
        chk("uf_words", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("uf_word0", got_q[0], 16'h0021);
            chk("uf_word1", got_q[1], 16'h0022);
        end
        chk("uf_err", underflow_err, 1);
        load_q.push_back(16'h0023);
        load_q.push_back(16'h0024);
        step(10);
        chk("uf_err_sticky", underflow_err, 1);
        chk("uf_words_after", got_q.size(), 4);

        // Reset with a full buffer and the error flag set
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) load_q.push_back(W'(16'h0030 + i));
        step(8);
        chk("rm_model_occ", buf_q.size(), 2);
        chk("rm_valid_before", m_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rm_during_valid", m_valid, 0);
        chk("rm_during_rd_en", fifo_rd_en, 0);
        chk("rm_during_data", m_data, 0);
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("rm_after_valid", m_valid, 0);
        chk("rm_after_rd_en", fifo_rd_en, 0);
        chk("rm_after_count", rd_count, 0);
        chk("rm_after_err", underflow_err, 0);

        // Reset while streaming (a read in flight)
        step(1);
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) load_q.push_back(W'(16'h0040 + i));
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("rs_after_valid", m_valid, 0);
        chk("rs_after_count", rd_count, 0);

        // Random traffic, occasional injected underflows and resets
        for (int i = 0; i < 1500; i++) begin
            step(1);
            m_ready = ($urandom_range(0, 3) != 0);
            rst     = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) begin
                nwords = $urandom_range(0, 3);
                for (int k = 0; k < nwords; k++) load_q.push_back(W'($urandom));
            end
            if ($urandom_range(0, 99) == 0) inj_req = 1'b1;
        end
        step(1);
        rst     = 1'b0;
        inj_req = 1'b0;
        m_ready = 1'b1;
        step(30);

        // Counter wrap after 65536 handshakes
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int i = 0; i < 65536; i++) load_q.push_back(W'($urandom));
        for (int i = 0; i < 66000 && hs_cnt < 65535; i++) step(1);
        chk("wrap_pre_hs", hs_cnt, 65535);
        chk("wrap_pre_count", rd_count, 16'hFFFF);
        for (int i = 0; i < 10 && hs_cnt < 65536; i++) step(1);
        chk("wrap_hs", hs_cnt, 65536);
        chk("wrap_count", rd_count, 16'h0000);
        step(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
